m_adder_arb: RTL and testbench
==============================

Name: m_adder_arb

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit ripple-carry adder datapath (m_ADDER-class, built from m_FA cells) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The winning pair is driven through the shared adder, and the sum is registered and returned on a single response channel tagged with the requester ID.
- Sits between client units (address generators, counters) and the single physical adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and sum width.
- IDW, 2, response ID width; must equal ceil(log2(NREQ)).

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_req_valid  in  NREQ  per-requester request valid.
- w_req_ready  out  NREQ  per-requester accept; at most one bit set.
- w_req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- w_req_b  in  NREQ*WIDTH  operand B, same packing as w_req_a.
- w_rsp_valid  out  1  response valid.
- w_rsp_ready  in  1  response consumer accept.
- w_rsp_id  out  IDW  index of the requester that produced the response.
- w_rsp_sum  out  WIDTH  sum (A+B) mod 2^WIDTH.
- w_rsp_cout  out  1  carry out of the MSB.

Behaviour:
- Reset (async, w_rst_n=0): w_rsp_valid=0, w_rsp_id=0, w_rsp_sum=0, w_rsp_cout=0, round-robin pointer r_ptr=0. Any pending result is discarded; w_req_ready=0 while in reset.
- Output-slot states:
  - EMPTY: w_rsp_valid=0.
  - FULL: w_rsp_valid=1.
- Accept enable: acc_en = EMPTY | (FULL & w_rsp_ready). This gives back-to-back throughput of 1 per cycle.
- Grant (combinational):
  - Scan w_req_valid starting at index r_ptr, wrapping modulo NREQ. The first set bit is the winner g.
  - w_req_ready[g] = acc_en. All other ready bits are 0.
  - If no valid bit is set, all ready bits are 0.
- Transfer: occurs on w_req_valid[g] & w_req_ready[g] at a clock edge. On that edge:
  - {cout,sum} <= a_g + b_g, computed through one adder instance with carry-in 0.
  - w_rsp_id <= g.
  - State -> FULL.
  - r_ptr <= (g+1) mod NREQ.
- Latency: result is visible exactly 1 cycle after the accepting edge.
- FULL & w_rsp_ready & no new transfer -> EMPTY. Response outputs hold their last values.
- FULL & !w_rsp_ready: response outputs are frozen, and every w_req_ready stays 0.
- Requesters must hold a/b stable while valid and unaccepted. Dropping valid before acceptance is legal; the request is simply not served.
- r_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Adder width rules: operands are unsigned; cout is the true carry out of the MSB, and overflow wraps.
- Reset mid-operation (FULL, unconsumed): the response is lost, and the requester is not re-served automatically.

Optional Feature:
- Macro ADDER_ARB_SUB_EN.
- Defined:
  - Adds input port w_req_sub[NREQ].
  - For the winner, if sub=1, the shared adder computes A + ~B + 1, i.e. A-B mod 2^WIDTH. w_rsp_cout=1 means no borrow.
  - The op bit is captured with the operands.
- Undefined: the port is absent and the block always adds with carry-in 0.

Decomposition:
- Shared constants in the common include/package: default NREQ, WIDTH, and IDW values, plus the state encodings ST_EMPTY=1'b0 and ST_FULL=1'b1.
- One natural sub-module: m_rr_pick.
  - Combinational rotating priority picker.
  - Inputs: NREQ-bit valid vector and r_ptr. Outputs: one-hot grant and its index.
- The adder is an instance of the existing ripple adder, widened to provide the carry-out and carry-in (carry-in used for subtraction).

Test Plan:
1. Req0 only, a=321, b=4444, w_rsp_ready=1 -> next cycle w_rsp_valid=1, sum=4765, id=0, cout=0; r_ptr=1.
2. All four requesters valid, a=i*1024, b=2048, w_rsp_ready=1 for 4 cycles -> grants in order 0,1,2,3; sums 2048, 3072, 4096, 5120, one per cycle.
3. a=32'hFFFFFFFF, b=1 -> sum=0, cout=1. With a=32'h7FFFFFFF, b=1 -> sum=32'h80000000, cout=0.
4. Backpressure: response FULL, w_rsp_ready=0 for 5 cycles with req1 valid -> w_req_ready=0 throughout and the response is stable. When ready rises, req1 is accepted that same cycle.
5. Async reset asserted mid-cycle while FULL -> w_rsp_valid drops immediately and r_ptr=0. After release, req2 valid with a=5, b=7 -> sum=12, id=2.
6. With ADDER_ARB_SUB_EN: req3 sub=1, a=10, b=3 -> sum=7, cout=1. Then a=3, b=10 -> sum=32'hFFFFFFF9, cout=0.

Source files
------------

// File: rtl/m_adder_arb_pkg.sv
// Shared defaults and output-slot state encodings for the m_adder_arb arbiter.
// Optional subtract support is controlled by the ADDER_ARB_SUB_EN macro in m_adder_arb.sv.
package m_adder_arb_pkg;

    localparam int ADDER_ARB_NREQ  = 4;
    localparam int ADDER_ARB_WIDTH = 32;
    localparam int ADDER_ARB_IDW   = 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/m_adder_arb_fa.sv
// Full-adder cell and the ripple-carry adder built from it.
// The adder exposes carry-in and carry-out so that the arbiter can also subtract.
module m_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module m_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        m_fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/m_adder_arb_pick.sv
// Rotating-priority picker: scans the valid vector from ptr upward, wrapping
// modulo NREQ, and returns the first set bit as a one-hot grant plus its index.
module m_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!any && valid[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/m_adder_arb.sv
// Round-robin arbiter sharing one ripple adder among NREQ requesters, with a
// single registered response slot. Define ADDER_ARB_SUB_EN to add per-request subtract.
module m_adder_arb
    import m_adder_arb_pkg::*;
#(
    parameter int NREQ  = ADDER_ARB_NREQ,
    parameter int WIDTH = ADDER_ARB_WIDTH,
    parameter int IDW   = ADDER_ARB_IDW
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic [NREQ-1:0]       w_req_valid,
    output logic [NREQ-1:0]       w_req_ready,
    input  logic [NREQ*WIDTH-1:0] w_req_a,
    input  logic [NREQ*WIDTH-1:0] w_req_b,
`ifdef ADDER_ARB_SUB_EN
    input  logic [NREQ-1:0]       w_req_sub,
`endif
    output logic                  w_rsp_valid,
    input  logic                  w_rsp_ready,
    output logic [IDW-1:0]        w_rsp_id,
    output logic [WIDTH-1:0]      w_rsp_sum,
    output logic                  w_rsp_cout
);

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             acc_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [IDW-1:0]   ptr_next;

    m_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (w_req_valid),
        .ptr   (r_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Reset is folded in so no requester sees ready while the block is held in reset.
    assign acc_en      = w_rst_n & ((r_state == ST_EMPTY) | w_rsp_ready);
    assign w_req_ready = pick_grant & {NREQ{acc_en}};
    assign xfer        = pick_any & acc_en;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = w_req_a[i*WIDTH +: WIDTH];
                sel_b = w_req_b[i*WIDTH +: WIDTH];
`ifdef ADDER_ARB_SUB_EN
                sel_sub = w_req_sub[i];
`endif
            end
        end
    end

    // Subtraction reuses the adder as A + ~B + 1, so cout=1 means no borrow.
    assign add_b = sel_sub ? ~sel_b : sel_b;

    m_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (sel_a),
        .b    (add_b),
        .cin  (sel_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign ptr_next = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_EMPTY;
            r_ptr      <= '0;
            w_rsp_id   <= '0;
            w_rsp_sum  <= '0;
            w_rsp_cout <= 1'b0;
        end else if (xfer) begin
            r_state    <= ST_FULL;
            r_ptr      <= ptr_next;
            w_rsp_id   <= pick_idx;
            w_rsp_sum  <= add_sum;
            w_rsp_cout <= add_cout;
        end else if ((r_state == ST_FULL) && w_rsp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign w_rsp_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_m_adder_arb.sv
// Directed self-checking bench for m_adder_arb; subtract steps run only when
// ADDER_ARB_SUB_EN is defined.
module tb_m_adder_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  w_clk;
    logic                  w_rst_n;
    logic [NREQ-1:0]       w_req_valid;
    logic [NREQ-1:0]       w_req_ready;
    logic [NREQ*WIDTH-1:0] w_req_a;
    logic [NREQ*WIDTH-1:0] w_req_b;
`ifdef ADDER_ARB_SUB_EN
    logic [NREQ-1:0]       w_req_sub;
`endif
    logic                  w_rsp_valid;
    logic                  w_rsp_ready;
    logic [IDW-1:0]        w_rsp_id;
    logic [WIDTH-1:0]      w_rsp_sum;
    logic                  w_rsp_cout;

    int total;
    int bad;

    m_adder_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .w_req_a     (w_req_a),
        .w_req_b     (w_req_b),
`ifdef ADDER_ARB_SUB_EN
        .w_req_sub   (w_req_sub),
`endif
        .w_rsp_valid (w_rsp_valid),
        .w_rsp_ready (w_rsp_ready),
        .w_rsp_id    (w_rsp_id),
        .w_rsp_sum   (w_rsp_sum),
        .w_rsp_cout  (w_rsp_cout)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic [IDW-1:0] id,
                            input logic [WIDTH-1:0] sum, input logic cout);
        checkOutput({tag, "_valid"}, 64'(w_rsp_valid), 64'(1'b1));
        checkOutput({tag, "_id"},    64'(w_rsp_id),    64'(id));
        checkOutput({tag, "_sum"},   64'(w_rsp_sum),   64'(sum));
        checkOutput({tag, "_cout"},  64'(w_rsp_cout),  64'(cout));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        w_rst_n     = 1'b0;
        w_req_valid = '0;
        w_req_a     = '0;
        w_req_b     = '0;
        w_rsp_ready = 1'b1;
`ifdef ADDER_ARB_SUB_EN
        w_req_sub   = '0;
`endif

        // Reset state, with a request already presented
        w_req_valid = 4'b0001;
        w_req_a[0*WIDTH +: WIDTH] = 32'd321;
        w_req_b[0*WIDTH +: WIDTH] = 32'd4444;
        #12;
        checkOutput("rst_valid", 64'(w_rsp_valid), 64'd0);
        checkOutput("rst_id",    64'(w_rsp_id),    64'd0);
        checkOutput("rst_sum",   64'(w_rsp_sum),   64'd0);
        checkOutput("rst_cout",  64'(w_rsp_cout),  64'd0);
        checkOutput("rst_ready", 64'(w_req_ready), 64'd0);
        checkOutput("rst_ptr",   64'(dut.r_ptr),   64'd0);

        // Step 1: requester 0 alone
        w_rst_n = 1'b1;
        #1;
        checkOutput("s1_ready", 64'(w_req_ready), 64'b0001);
        tick();
        checkRsp("s1", 2'd0, 32'd4765, 1'b0);
        checkOutput("s1_ptr", 64'(dut.r_ptr), 64'd1);

        // Requester 3 wraps the pointer back to 0 and checks full overflow
        w_req_valid = 4'b1000;
        w_req_a[3*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        w_req_b[3*WIDTH +: WIDTH] = 32'd1;
        #1;
        checkOutput("s3a_ready", 64'(w_req_ready), 64'b1000);
        tick();
        checkRsp("s3a", 2'd3, 32'd0, 1'b1);
        checkOutput("s3a_ptr", 64'(dut.r_ptr), 64'd0);

        // Step 2: all four valid, one grant per cycle in rotating order
        w_req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            w_req_a[i*WIDTH +: WIDTH] = 32'(i * 1024);
            w_req_b[i*WIDTH +: WIDTH] = 32'd2048;
        end
        #1;
        checkOutput("s2_ready0", 64'(w_req_ready), 64'b0001);
        tick();
        checkRsp("s2_r0", 2'd0, 32'd2048, 1'b0);
        checkOutput("s2_ready1", 64'(w_req_ready), 64'b0010);
        tick();
        checkRsp("s2_r1", 2'd1, 32'd3072, 1'b0);
        checkOutput("s2_ready2", 64'(w_req_ready), 64'b0100);
        tick();
        checkRsp("s2_r2", 2'd2, 32'd4096, 1'b0);
        checkOutput("s2_ready3", 64'(w_req_ready), 64'b1000);
        tick();
        checkRsp("s2_r3", 2'd3, 32'd5120, 1'b0);
        checkOutput("s2_ptr", 64'(dut.r_ptr), 64'd0);

        // Step 3b: signed-overflow boundary without carry out
        w_req_valid = 4'b0001;
        w_req_a[0*WIDTH +: WIDTH] = 32'h7FFF_FFFF;
        w_req_b[0*WIDTH +: WIDTH] = 32'd1;
        tick();
        checkRsp("s3b", 2'd0, 32'h8000_0000, 1'b0);
        checkOutput("s3b_ptr", 64'(dut.r_ptr), 64'd1);

        // Step 4: backpressure holds the slot and blocks all grants
        w_req_valid = 4'b0010;
        w_rsp_ready = 1'b0;
        w_req_a[1*WIDTH +: WIDTH] = 32'd100;
        w_req_b[1*WIDTH +: WIDTH] = 32'd200;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("s4_ready_blk", 64'(w_req_ready), 64'd0);
            checkRsp("s4_hold", 2'd0, 32'h8000_0000, 1'b0);
            tick();
        end
        w_rsp_ready = 1'b1;
        #1;
        checkOutput("s4_ready_rise", 64'(w_req_ready), 64'b0010);
        tick();
        checkRsp("s4", 2'd1, 32'd300, 1'b0);
        checkOutput("s4_ptr", 64'(dut.r_ptr), 64'd2);

        // Step 5: asynchronous reset while the slot is full
        w_req_valid = '0;
        w_rsp_ready = 1'b0;
        #2;
        w_rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_valid", 64'(w_rsp_valid), 64'd0);
        checkOutput("s5_rst_ptr",   64'(dut.r_ptr),   64'd0);
        checkOutput("s5_rst_sum",   64'(w_rsp_sum),   64'd0);
        #1;
        w_rst_n     = 1'b1;
        w_rsp_ready = 1'b1;
        w_req_valid = 4'b0100;
        w_req_a[2*WIDTH +: WIDTH] = 32'd5;
        w_req_b[2*WIDTH +: WIDTH] = 32'd7;
        #1;
        checkOutput("s5_ready", 64'(w_req_ready), 64'b0100);
        tick();
        checkRsp("s5", 2'd2, 32'd12, 1'b0);
        checkOutput("s5_ptr", 64'(dut.r_ptr), 64'd3);

`ifdef ADDER_ARB_SUB_EN
        // Step 6: subtraction, cout=1 means no borrow
        w_req_valid  = 4'b1000;
        w_req_sub    = 4'b1000;
        w_req_a[3*WIDTH +: WIDTH] = 32'd10;
        w_req_b[3*WIDTH +: WIDTH] = 32'd3;
        tick();
        checkRsp("s6a", 2'd3, 32'd7, 1'b1);
        w_req_a[3*WIDTH +: WIDTH] = 32'd3;
        w_req_b[3*WIDTH +: WIDTH] = 32'd10;
        tick();
        checkRsp("s6b", 2'd3, 32'hFFFF_FFF9, 1'b0);
        w_req_sub = '0;
`endif

        // Slot drains once nothing more is requested
        w_req_valid = '0;
        tick();
        checkOutput("drain_valid", 64'(w_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
